// File: rtl/ball_direction_ctrl.sv
`timescale 1ns/1ps
// ball_direction_ctrl
//   Closes the ball loop for a Pong-style game. Watches the ball position and
//   both paddle tops, and drives the ball mover's direction inputs. It flips
//   the direction on wall and paddle contact, detects misses, keeps both
//   players' scores, and holds the ball at centre for a serve delay between
//   points.
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-high reset
//   ball_x       ball top-left X (px)
//   ball_y       ball top-left Y (px)
//   paddle_l_y   left paddle top Y (px)
//   paddle_r_y   right paddle top Y (px)
//   dir_horiz    1 = moving right, 0 = moving left (registered)
//   dir_vert     1 = moving down, 0 = moving up (registered)
//   serve_reset  high while the ball must be held at centre; ORed into the
//                ball mover's reset
//   hit_pulse    one-cycle pulse on each paddle hit
//   score_l      left player score
//   score_r      right player score
//   game_over    match finished (tied 0 unless GAME_OVER_EN)
//
// Build option
//   GAME_OVER_EN  when defined, reaching WIN_SCORE ends the match: the block
//                 freezes in GAME_OVER until reset. When undefined, scores
//                 wrap 9 -> 0 and WIN_SCORE does not exist.

module ball_direction_ctrl #(
  parameter int unsigned BALL_SIZE      = 15,
  parameter int unsigned DISPLAY_WIDTH  = 639,
  parameter int unsigned DISPLAY_HEIGHT = 479,
  parameter int unsigned PADDLE_HEIGHT  = 64,
  parameter int unsigned PADDLE_L_X     = 16,
  parameter int unsigned PADDLE_R_X     = 608,
  parameter int unsigned SERVE_DELAY    = 25000000
`ifdef GAME_OVER_EN
  ,
  parameter int unsigned WIN_SCORE      = 9
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] ball_x,
  input  logic [9:0] ball_y,
  input  logic [9:0] paddle_l_y,
  input  logic [9:0] paddle_r_y,
  output logic       dir_horiz,
  output logic       dir_vert,
  output logic       serve_reset,
  output logic       hit_pulse,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic       game_over
);

  localparam int unsigned X_MAX = DISPLAY_WIDTH - BALL_SIZE;
  localparam int unsigned Y_MAX = DISPLAY_HEIGHT - BALL_SIZE;
  localparam int unsigned CNT_W = $clog2(SERVE_DELAY + 1);
  localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_DELAY - 1);

  typedef enum logic [1:0] {
    S_SERVE     = 2'd0,
    S_PLAY      = 2'd1,
    S_GAME_OVER = 2'd2
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] serve_cnt_q;
  logic             dir_horiz_q, dir_vert_q, serve_reset_q, hit_q;
  logic [3:0]       score_l_q, score_r_q;
  logic [3:0]       score_l_d, score_r_d;
  logic             win_l, win_r;

  // Zero-extend to 11 bits so y + size never wraps near the bottom edge.
  logic [10:0] bx, by, pl, pr;
  assign bx = {1'b0, ball_x};
  assign by = {1'b0, ball_y};
  assign pl = {1'b0, paddle_l_y};
  assign pr = {1'b0, paddle_r_y};

  logic overlap_l, overlap_r;
  logic bounce_top, bounce_bottom;
  logic hit_l, hit_r, miss_l, miss_r;

  assign overlap_l = (by + 11'(BALL_SIZE) >= pl) && (by <= pl + 11'(PADDLE_HEIGHT));
  assign overlap_r = (by + 11'(BALL_SIZE) >= pr) && (by <= pr + 11'(PADDLE_HEIGHT));

  // Each flip is gated by the current heading, so a ball parked on a
  // saturated edge turns around once and is then ignored.
  assign bounce_top    = !dir_vert_q && (ball_y == 10'd0);
  assign bounce_bottom =  dir_vert_q && (by >= 11'(Y_MAX));

  // A paddle overlap wins over a miss even at the screen edge.
  assign hit_l  = !dir_horiz_q && (bx <= 11'(PADDLE_L_X)) && overlap_l;
  assign miss_l = !dir_horiz_q && (ball_x == 10'd0) && !hit_l;
  assign hit_r  =  dir_horiz_q && (bx >= 11'(PADDLE_R_X)) && overlap_r;
  assign miss_r =  dir_horiz_q && (bx >= 11'(X_MAX)) && !hit_r;

`ifdef GAME_OVER_EN
  assign score_l_d = score_l_q + 4'd1;
  assign score_r_d = score_r_q + 4'd1;
  assign win_l     = (score_l_d == 4'(WIN_SCORE));
  assign win_r     = (score_r_d == 4'(WIN_SCORE));
`else
  assign score_l_d = (score_l_q == 4'd9) ? 4'd0 : score_l_q + 4'd1;
  assign score_r_d = (score_r_q == 4'd9) ? 4'd0 : score_r_q + 4'd1;
  assign win_l     = 1'b0;
  assign win_r     = 1'b0;
`endif

`ifdef GAME_OVER_EN
  logic game_over_q;
`endif

  // NOTE: every register below is state, so the block uses only non-blocking
  // assignments; all reads see the pre-edge values regardless of order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_SERVE;
      serve_cnt_q   <= '0;
      dir_horiz_q   <= 1'b1;
      dir_vert_q    <= 1'b1;
      serve_reset_q <= 1'b1;
      hit_q         <= 1'b0;
      score_l_q     <= 4'd0;
      score_r_q     <= 4'd0;
`ifdef GAME_OVER_EN
      game_over_q   <= 1'b0;
`endif
    end else begin
      // NOTE: default first so hit_pulse drops after one cycle unless a new
      // hit re-asserts it below.
      hit_q <= 1'b0;
      case (state_q)
        S_SERVE: begin
          serve_reset_q <= 1'b1;
          if (serve_cnt_q == SERVE_LAST) begin
            state_q       <= S_PLAY;
            serve_cnt_q   <= '0;
            serve_reset_q <= 1'b0;
          end else begin
            serve_cnt_q <= serve_cnt_q + 1'b1;
          end
        end
        S_PLAY: begin
          if (bounce_top)         dir_vert_q <= 1'b1;
          else if (bounce_bottom) dir_vert_q <= 1'b0;

          if (hit_l) begin
            dir_horiz_q <= 1'b1;
            hit_q       <= 1'b1;
          end else if (hit_r) begin
            dir_horiz_q <= 1'b0;
            hit_q       <= 1'b1;
          end else if (miss_l) begin
            // Next serve heads toward the player who just scored.
            score_r_q     <= score_r_d;
            dir_horiz_q   <= 1'b1;
            serve_reset_q <= 1'b1;
            state_q       <= win_r ? S_GAME_OVER : S_SERVE;
`ifdef GAME_OVER_EN
            game_over_q   <= win_r;
`endif
          end else if (miss_r) begin
            score_l_q     <= score_l_d;
            dir_horiz_q   <= 1'b0;
            serve_reset_q <= 1'b1;
            state_q       <= win_l ? S_GAME_OVER : S_SERVE;
`ifdef GAME_OVER_EN
            game_over_q   <= win_l;
`endif
          end
        end
        S_GAME_OVER: begin
          // Terminal: only reset leaves this state.
          serve_reset_q <= 1'b1;
        end
        default: begin
          state_q       <= S_SERVE;
          serve_cnt_q   <= '0;
          serve_reset_q <= 1'b1;
        end
      endcase
    end
  end

  assign dir_horiz   = dir_horiz_q;
  assign dir_vert    = dir_vert_q;
  assign serve_reset = serve_reset_q;
  assign hit_pulse   = hit_q;
  assign score_l     = score_l_q;
  assign score_r     = score_r_q;
`ifdef GAME_OVER_EN
  assign game_over   = game_over_q;
`else
  assign game_over   = 1'b0;
`endif

endmodule

// File: tb/tb_ball_direction_ctrl.sv
`timescale 1ns/1ps
// tb_ball_direction_ctrl
//   Directed stimulus with hand-computed expected output snapshots. The
//   stimulus process pushes each expected snapshot, tagged with the clock
//   cycle it belongs to, into a queue; a separate monitor compares the DUT
//   outputs against the queue on every falling edge.
//   Snapshot packing: {dir_horiz, dir_vert, serve_reset, hit_pulse,
//                      score_l[3:0], score_r[3:0], game_over}.

module tb_ball_direction_ctrl;

  logic       clk;
  logic       reset;
  logic [9:0] ball_x, ball_y, paddle_l_y, paddle_r_y;
  logic       dir_horiz, dir_vert, serve_reset, hit_pulse, game_over;
  logic [3:0] score_l, score_r;

  ball_direction_ctrl #(.SERVE_DELAY(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .paddle_l_y (paddle_l_y),
    .paddle_r_y (paddle_r_y),
    .dir_horiz  (dir_horiz),
    .dir_vert   (dir_vert),
    .serve_reset(serve_reset),
    .hit_pulse  (hit_pulse),
    .score_l    (score_l),
    .score_r    (score_r),
    .game_over  (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int          cyc;
    string       name;
    logic [12:0] val;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Hand-tracked expected outputs.
  logic       e_dh, e_dv, e_sr, e_hit, e_go;
  logic [3:0] e_sl, e_scr;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", nm, cyc, act, req);
    end
  endtask

  function automatic logic [12:0] snap();
    return {dir_horiz, dir_vert, serve_reset, hit_pulse, score_l, score_r, game_over};
  endfunction

  function automatic logic [12:0] expv();
    return {e_dh, e_dv, e_sr, e_hit, e_sl, e_scr, e_go};
  endfunction

  task automatic push(input int dly, input string nm);
    exp_t e;
    e.cyc  = cyc + dly;
    e.name = nm;
    e.val  = expv();
    q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: compare every snapshot that is due this cycle.
  always @(negedge clk) begin
    while (q.size() != 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      check(e.name, 32'(snap()), 32'(e.val));
    end
  end

  // Serve hold after reset release or a miss: serve_reset high for four
  // cycles, low on the fourth check.
  task automatic serve_wait(input string nm);
    for (int d = 1; d <= 4; d++) begin
      e_sr = (d < 4);
      push(d, nm);
    end
    tick(4);
  endtask

  // One point won by the left player: left-paddle hit to turn the ball
  // right, then a miss on the right side.
  task automatic point();
    ball_x = 10'd16; ball_y = 10'd200; paddle_l_y = 10'd190;
    e_dh = 1'b1; e_hit = 1'b1;
    push(1, "pt_hit_l");
    tick(1);
    ball_x = 10'd624; paddle_r_y = 10'd0;
    e_dh = 1'b0; e_hit = 1'b0; e_sr = 1'b1;
`ifdef GAME_OVER_EN
    e_sl = e_sl + 4'd1;
    if (e_sl == 4'd9) e_go = 1'b1;
`else
    e_sl = (e_sl == 4'd9) ? 4'd0 : e_sl + 4'd1;
`endif
    push(1, "pt_miss_r");
    for (int d = 2; d <= 5; d++) begin
      e_sr = e_go ? 1'b1 : (d < 5);
      push(d, "pt_serve");
    end
    tick(5);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    ball_x = 10'd320; ball_y = 10'd240; paddle_l_y = 10'd200; paddle_r_y = 10'd200;
    e_dh = 1'b1; e_dv = 1'b1; e_sr = 1'b1; e_hit = 1'b0;
    e_sl = 4'd0; e_scr = 4'd0; e_go = 1'b0;
    tick(2);
    check("reset_state", 32'(snap()), 32'(expv()));

    // 1. Reset release: four serve cycles, then PLAY.
    reset = 1'b0;
    serve_wait("serve_after_reset");

    // 2. Bottom wall held for five cycles: one flip, then stays up.
    ball_y = 10'd464;
    e_dv = 1'b0;
    for (int d = 1; d <= 5; d++) push(d, "wall_bottom");
    tick(5);

    // Right hit to head left, then a near-miss at x=17, then left hit.
    ball_x = 10'd608; ball_y = 10'd200; paddle_r_y = 10'd190;
    e_dh = 1'b0; e_hit = 1'b1;
    push(1, "hit_r");
    tick(1);
    ball_x = 10'd17; paddle_l_y = 10'd190;
    e_hit = 1'b0;
    push(1, "no_hit_x17");
    tick(1);
    // 3. Left paddle hit.
    ball_x = 10'd16;
    e_dh = 1'b1; e_hit = 1'b1;
    push(1, "hit_l");
    tick(1);
    ball_x = 10'd320;
    e_hit = 1'b0;
    push(1, "hit_one_cycle");
    tick(1);

    // 4. Left miss: score_r increments, serve toward the right.
    ball_x = 10'd608; paddle_r_y = 10'd190;
    e_dh = 1'b0; e_hit = 1'b1;
    push(1, "hit_r2");
    tick(1);
    ball_x = 10'd0; ball_y = 10'd300; paddle_l_y = 10'd100;
    e_dh = 1'b1; e_hit = 1'b0; e_scr = 4'd1; e_sr = 1'b1;
    push(1, "miss_l");
    tick(1);
    // Top-wall contact during SERVE must not flip dir_vert.
    ball_y = 10'd0;
    serve_wait("serve_after_miss");

    // 5. Corner: right paddle hit and top wall in the same cycle.
    ball_x = 10'd624; ball_y = 10'd0; paddle_r_y = 10'd0;
    e_dh = 1'b0; e_dv = 1'b1; e_hit = 1'b1;
    push(1, "corner");
    tick(1);
    ball_x = 10'd320; ball_y = 10'd240;
    e_hit = 1'b0;
    push(1, "corner_after");
    tick(1);

    // Overlap edges: ball bottom touching left paddle top at x=0 is a hit;
    // ball top at right paddle bottom is a hit.
    ball_x = 10'd0; ball_y = 10'd175; paddle_l_y = 10'd190;
    e_dh = 1'b1; e_hit = 1'b1;
    push(1, "hit_l_x0_edge");
    tick(1);
    ball_x = 10'd608; ball_y = 10'd200; paddle_r_y = 10'd136;
    e_dh = 1'b0; e_hit = 1'b1;
    push(1, "hit_r_edge");
    tick(1);
    ball_x = 10'd320;
    e_hit = 1'b0;
    push(1, "edge_after");
    tick(1);

    // 6. Left player scores up to 9 (and past it without game over).
`ifdef GAME_OVER_EN
    repeat (9) point();
    ball_x = 10'd16; ball_y = 10'd200; paddle_l_y = 10'd190;
    for (int d = 1; d <= 100; d++) push(d, "game_over_hold");
    tick(100);
`else
    repeat (10) point();
`endif

    // Reset mid-operation takes effect without a clock edge.
    reset = 1'b1;
    #1;
    e_dh = 1'b1; e_dv = 1'b1; e_sr = 1'b1; e_hit = 1'b0;
    e_sl = 4'd0; e_scr = 4'd0; e_go = 1'b0;
    check("async_reset", 32'(snap()), 32'(expv()));
    push(1, "reset_held");
    tick(1);
    reset = 1'b0;
    ball_x = 10'd320; ball_y = 10'd240;
    serve_wait("serve_after_rst2");

    for (int i = 0; i < 20 && q.size() != 0; i++) tick(1);
    check("queue_drain", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
